// File: rtl/dac_pkg.sv
// Shared definitions for the SPI DAC arbiter: FSM encoding, DAC word
// constants and a width helper for requester indices.
package dac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int         DW_DAC     = 16;
   localparam logic [3:0] CTRL_DAC_A = 4'b0011;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/spi_dac_arbiter_rr_pick.sv
// Round-robin picker: first set request bit scanning from ptr upward,
// wrapping at NREQ-1 so indices >= NREQ are never produced.
module rr_pick
   import dac_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int IW   = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [IW:0] j;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = '0;
      for (int i = 0; i < NREQ; i++) begin
         j = {1'b0, ptr} + (IW+1)'(i);
         if (j >= (IW+1)'(NREQ)) j = j - (IW+1)'(NREQ);
         if (!any && req[j[IW-1:0]]) begin
            any                 = 1'b1;
            idx                 = j[IW-1:0];
            onehot[j[IW-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_dac_arbiter.sv
// Shares one SPI DAC writer among NREQ requesters: round-robin grant,
// start pulse, wait for end-of-write with a watchdog, done/err pulse.
module spi_dac_arbiter
   import dac_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int DW      = DW_DAC,
   parameter int TMO_CYC = 2000,
   parameter int TMO_W   = 11
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ*DW-1:0] din_i,
   output logic [NREQ-1:0]    gnt_o,
   output logic [NREQ-1:0]    done_o,
   output logic               err_o,
   output logic               busy_o,
   output logic               strw_o,
   output logic [DW-1:0]      dout_o,
   input  logic               eow_i
);

   localparam int IW = clog2(NREQ);

   state_t            state_q, state_n;
   logic [IW-1:0]     k_q, k_n;
   logic [IW-1:0]     ptr_q, ptr_n;
   logic [TMO_W-1:0]  cnt_q, cnt_n;
   logic [NREQ-1:0]   gnt_q, gnt_n;
   logic [NREQ-1:0]   done_q, done_n;
   logic              err_q, err_n;
   logic              busy_q, busy_n;
   logic              strw_q, strw_n;
   logic [DW-1:0]     dout_q, dout_n;

   logic [NREQ-1:0]   pick_oh;
   logic [IW-1:0]     pick_idx;
   logic              pick_any;
   logic [DW-1:0]     pick_word;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req    (req_i),
      .ptr    (ptr_q),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      pick_word = '0;
      for (int k = 0; k < NREQ; k++)
         if (pick_oh[k]) pick_word = din_i[k*DW +: DW];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         strw_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_n;
         k_q     <= k_n;
         ptr_q   <= ptr_n;
         cnt_q   <= cnt_n;
         gnt_q   <= gnt_n;
         done_q  <= done_n;
         err_q   <= err_n;
         busy_q  <= busy_n;
         strw_q  <= strw_n;
         dout_q  <= dout_n;
      end
   end

   // Outputs are computed for the state being entered, so every port is a flop.
   always_comb begin
      state_n = state_q;
      k_n     = k_q;
      ptr_n   = ptr_q;
      cnt_n   = cnt_q;
      gnt_n   = gnt_q;
      done_n  = '0;
      err_n   = 1'b0;
      busy_n  = busy_q;
      strw_n  = 1'b0;
      dout_n  = dout_q;
      unique case (state_q)
         ST_IDLE: begin
            gnt_n  = '0;
            busy_n = 1'b0;
            if (pick_any) begin
               state_n = ST_ISSUE;
               k_n     = pick_idx;
               dout_n  = pick_word;
               gnt_n   = pick_oh;
               busy_n  = 1'b1;
               strw_n  = 1'b1;
            end
         end
         ST_ISSUE: begin
            cnt_n   = '0;
            state_n = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_n = cnt_q + 1'b1;
            if (eow_i) begin
               state_n = ST_DONE;
               done_n  = gnt_q;
            end else if (cnt_q == TMO_W'(TMO_CYC - 1)) begin
               state_n = ST_DONE;
               done_n  = gnt_q;
               err_n   = 1'b1;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
            if (k_q == IW'(NREQ - 1)) ptr_n = '0;
            else                      ptr_n = k_q + 1'b1;
         end
      endcase
   end

   assign gnt_o  = gnt_q;
   assign done_o = done_q;
   assign err_o  = err_q;
   assign busy_o = busy_q;
   assign strw_o = strw_q;
   assign dout_o = dout_q;

endmodule
